// File: rtl/cfu_cmd_fifo.sv
// cfu_cmd_fifo: first-word-fall-through command FIFO between the CPU and a CFU.
// Each entry holds one {function_id, inputs_0, inputs_1} command. Handshake
// outputs come from registered state only, so neither side ever sees a
// combinational path from the other.
module cfu_cmd_fifo #(
   parameter int DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       cmd_valid,
   output logic                       cmd_ready,
   input  logic [2:0]                 cmd_payload_function_id,
   input  logic [31:0]                cmd_payload_inputs_0,
   input  logic [31:0]                cmd_payload_inputs_1,
   output logic                       out_cmd_valid,
   input  logic                       out_cmd_ready,
   output logic [2:0]                 out_cmd_payload_function_id,
   output logic [31:0]                out_cmd_payload_inputs_0,
   output logic [31:0]                out_cmd_payload_inputs_1,
   output logic [$clog2(DEPTH):0]     level
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

   typedef struct packed {
      logic [2:0]  function_id;
      logic [31:0] inputs_0;
      logic [31:0] inputs_1;
   } cmd_t;

   cmd_t          mem [DEPTH];
   cmd_t          head;
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [AW:0]   level_q;
   logic          push;
   logic          pop;

   // Handshakes depend only on the stored level.
   assign cmd_ready     = (level_q != FULL_LVL);
   assign out_cmd_valid = (level_q != '0);
   assign push          = cmd_valid && cmd_ready;
   assign pop           = out_cmd_valid && out_cmd_ready;
   assign level         = level_q;

   // Head entry is always presented; its value only matters while valid.
   assign head                        = mem[rd_ptr];
   assign out_cmd_payload_function_id = head.function_id;
   assign out_cmd_payload_inputs_0    = head.inputs_0;
   assign out_cmd_payload_inputs_1    = head.inputs_1;

   // Storage: written on push only, no reset needed since level gates visibility.
   always_ff @(posedge clk) begin
      if (push && !reset)
         mem[wr_ptr] <= '{function_id: cmd_payload_function_id,
                          inputs_0:    cmd_payload_inputs_0,
                          inputs_1:    cmd_payload_inputs_1};
   end

   // Pointers and level; power-of-two depth lets the pointers wrap naturally.
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         level_q <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({push, pop})
            2'b10:   level_q <= level_q + (AW+1)'(1);
            2'b01:   level_q <= level_q - (AW+1)'(1);
            default: level_q <= level_q;
         endcase
      end
   end

endmodule
